wb_retire_queue: RTL
====================

WB_RETIRE_QUEUE -- requirements
Module: wb_retire_queue

Parameters
REQ-001 SHALL provide parameter DATA_W, default 32: width of the result written to the register file.
REQ-002 SHALL provide parameter AW, default 5: register-file address width.
REQ-003 SHALL provide parameter PC_W, default 32: width of the PC carried for debug.
REQ-004 SHALL provide parameter DEPTH, default 2: retire-queue entries; a power of two and at least 2.

Interface
REQ-005 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have resetn, input, 1: synchronous, active-low reset.
REQ-007 SHALL have ms_to_ws_valid, input, 1: MEM holds a valid instruction.
REQ-008 SHALL have ms_to_ws_bus, input, PC_W+1+AW+DATA_W: packed {pc, gr_we, dest, result}, pc in the MSBs.
REQ-009 SHALL have ws_allowin, output, 1: the queue accepts an entry this cycle.
REQ-010 SHALL have rf_ready, input, 1: the shared RF write port is free this cycle.
REQ-011 SHALL have rf_we, output, 1: RF write strobe.
REQ-012 SHALL have rf_waddr, output, AW: RF write address.
REQ-013 SHALL have rf_wdata, output, DATA_W: RF write data.
REQ-014 SHALL have fw_raddr1 and fw_raddr2, input, AW each: ID read addresses to check.
REQ-015 SHALL have fw_hit1 and fw_hit2, output, 1 each: a pending write matches the corresponding read address.
REQ-016 SHALL have fw_data1 and fw_data2, output, DATA_W each: the forwarded value for each read address.
REQ-017 SHALL have ws_count, output, clog2(DEPTH+1): current occupancy.
REQ-018 SHALL have debug_wb_pc (PC_W), debug_wb_rf_we (4), debug_wb_rf_wnum (AW) and debug_wb_rf_wdata (DATA_W), all outputs: the trace of the retiring entry.

Function
REQ-019 SHALL store entries in a circular FIFO with head and tail pointers that wrap modulo DEPTH.
REQ-020 SHALL push one entry when ms_to_ws_valid & ws_allowin; the entry becomes visible the next cycle (1-cycle latency).
REQ-021 SHALL define retire = (count!=0) & (~head.gr_we | rf_ready), combinationally.
REQ-022 SHALL drive ws_allowin = (count!=DEPTH) | retire, so a full queue accepts a push in the same cycle as a pop.
REQ-023 SHALL pop the head on retire; an entry with gr_we=0 retires without waiting for rf_ready.
REQ-024 SHALL drive rf_we = (count!=0) & head.gr_we & rf_ready, with rf_waddr = head.dest and rf_wdata = head.result.
REQ-025 SHALL let head.gr_we=1 with count!=0 and rf_ready=0 stall the head: no pop, and entries behind it are held.
REQ-026 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers, including wrap from DEPTH-1 to 0.
REQ-027 SHALL ignore a push attempted while ws_allowin=0; the queue is unchanged.
REQ-028 SHALL assert fw_hitN iff some valid entry has gr_we=1 and dest==fw_raddrN and fw_raddrN!=0; fw_dataN is taken from the youngest such entry.
REQ-029 SHALL drive fw_dataN to 0 when fw_hitN=0.
REQ-030 SHALL base forwarding on stored entries only, including the head being written this cycle; the bus being pushed this cycle is not forwarded.
REQ-031 SHALL drive debug_wb_pc = head.pc, debug_wb_rf_we = {4{rf_we}}, debug_wb_rf_wnum = head.dest and debug_wb_rf_wdata = head.result.
REQ-032 SHALL write dest=0 with gr_we=1 to the RF normally (RF discards it), but never forward it.

Reset
REQ-033 SHALL, while resetn=0 at a rising edge, clear count, head and tail to 0 and zero all entry storage.
REQ-034 SHALL, after reset, drive ws_allowin=1, rf_we=0, fw_hit1/2=0, ws_count=0 and all debug outputs 0.
REQ-035 SHALL let reset mid-operation discard all entries, with no RF write in any cycle where resetn=0 is sampled.

Verification
REQ-036 SHALL cover single write: push {pc=0x1c000000, gr_we=1, dest=5, result=0xDEADBEEF}, rf_ready=1 -> next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, debug_wb_rf_we=0xF, count returns to 0.
REQ-037 SHALL cover fill and stall: rf_ready=0, push DEPTH writes -> count=DEPTH, ws_allowin=0; raise rf_ready -> one retire per cycle in push order.
REQ-038 SHALL cover full-queue pass-through: queue full, rf_ready=1, push each cycle -> ws_allowin=1, count stays DEPTH, pointers wrap and no entry is lost.
REQ-039 SHALL cover forwarding priority: entries dest=7 result=1 (older) and dest=7 result=2 (younger), fw_raddr1=7 -> fw_hit1=1, fw_data1=2; fw_raddr2=0 -> fw_hit2=0.
REQ-040 SHALL cover no-write bypass: head gr_we=0 with rf_ready=0 -> retires in one cycle with rf_we=0 and debug_wb_rf_we=0.
REQ-041 SHALL cover reset mid-flight: resetn=0 for one cycle with 2 entries queued -> count=0 and rf_we=0, and no stale entry is written afterwards.

Source files
------------

// File: rtl/wb_retire_queue.sv
// Writeback retire queue: buffers MEM results, retires them in order through a
// shared register-file write port, and forwards pending writes back to ID.
module wb_retire_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         ms_to_ws_valid,
  input  logic [PC_W+1+AW+DATA_W-1:0]  ms_to_ws_bus,
  output logic                         ws_allowin,
  input  logic                         rf_ready,
  output logic                         rf_we,
  output logic [AW-1:0]                rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic [AW-1:0]                fw_raddr1,
  input  logic [AW-1:0]                fw_raddr2,
  output logic                         fw_hit1,
  output logic                         fw_hit2,
  output logic [DATA_W-1:0]            fw_data1,
  output logic [DATA_W-1:0]            fw_data2,
  output logic [$clog2(DEPTH+1)-1:0]   ws_count,
  output logic [PC_W-1:0]              debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [AW-1:0]                debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              gr_we;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  entry_t            in_e;
  entry_t            head_e;
  logic              not_empty;
  logic              full;
  logic              retire_c;
  logic              push_c;
  logic [PTR_W-1:0]  fw_idx;

  assign in_e      = ms_to_ws_bus;
  assign head_e    = mem[head];
  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(DEPTH));

  // Head leaves when it needs no RF write or the port is free; never while in reset
  assign retire_c   = resetn & not_empty & (~head_e.gr_we | rf_ready);
  assign push_c     = ms_to_ws_valid & ws_allowin;
  assign ws_allowin = ~full | retire_c;

  // RF write port and retire trace driven straight from the head entry
  assign rf_we             = resetn & not_empty & head_e.gr_we & rf_ready;
  assign rf_waddr          = head_e.dest;
  assign rf_wdata          = head_e.result;
  assign ws_count          = count;
  assign debug_wb_pc       = head_e.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = head_e.dest;
  assign debug_wb_rf_wdata = head_e.result;

  // Queue storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_c) begin
        mem[tail] <= in_e;
        tail      <= tail + PTR_W'(1);
      end
      if (retire_c) begin
        head <= head + PTR_W'(1);
      end
      case ({push_c, retire_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Forwarding: walk oldest to youngest so the youngest matching write wins
  always_comb begin
    fw_hit1  = 1'b0;
    fw_hit2  = 1'b0;
    fw_data1 = '0;
    fw_data2 = '0;
    fw_idx   = head;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fw_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[fw_idx].gr_we) begin
        if ((fw_raddr1 != '0) && (mem[fw_idx].dest == fw_raddr1)) begin
          fw_hit1  = 1'b1;
          fw_data1 = mem[fw_idx].result;
        end
        if ((fw_raddr2 != '0) && (mem[fw_idx].dest == fw_raddr2)) begin
          fw_hit2  = 1'b1;
          fw_data2 = mem[fw_idx].result;
        end
      end
    end
  end

endmodule
